load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Data-memory access stage between execute and writeback. Accepts one load/store at a time,
//  drives a word-aligned memory bus with byte strobes, then returns load data lane-extracted
//  and size/sign-constrained via mem_utils::enforce_constraints. Flags misalignment, bus error and timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max WAIT cycles before timeout fault; 0 = timeout disabled
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  req_valid   in   1   request valid (execute side)
//  req_ready   out  1   request accepted when valid&ready
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned
//  req_size    in   2   00 byte, 01 half, 10/11 word
//  req_signed  in   1   sign-extend load result
//  req_write   in   1   1 = store, 0 = load
//  rsp_valid   out  1   response valid (writeback side)
//  rsp_ready   in   1   response consumed when valid&ready
//  rsp_rdata   out  32  load result (0 for stores and faults)
//  rsp_fault   out  2   00 none, 01 misaligned, 10 bus error/timeout
//  mem_valid   out  1   bus request valid
//  mem_ready   in   1   bus request accepted
//  mem_addr    out  32  {req_addr[31:2],2'b00}
//  mem_wdata   out  32  lane-replicated store data
//  mem_wstrb   out  4   byte strobes (0000 on loads)
//  mem_write   out  1   bus write enable
//  mem_rvalid  in   1   bus response/ack (loads and stores)
//  mem_rdata   in   32  bus read word
//  mem_err     in   1   bus error, qualified like mem_rvalid
// BEHAVIOUR
//  - Reset: state IDLE, every output 0 except req_ready=1; timeout counter 0.
//  - FSM IDLE->ISSUE->WAIT->RESP->IDLE. req_ready=1 only in IDLE; request fields latched on accept.
//  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): IDLE->RESP, fault 01, no mem_valid ever.
//  - ISSUE: mem_valid=1, mem_* stable until mem_ready; then WAIT (counter cleared).
//  - Strobes: byte wstrb=1<<addr[1:0], wdata={4{b}}; half 0011/1100, {2{h}}; word 1111, wdata as-is.
//  - WAIT: counter +1 per cycle; mem_err -> RESP fault 10; mem_rvalid -> RESP fault 00;
//    err beats rvalid same cycle; rvalid beats timeout same cycle; counter==TIMEOUT_CYCLES -> RESP fault 10.
//  - Load data: enforce_constraints(size, signed, mem_rdata >> (8*addr[1:0])), registered into rsp_rdata.
//  - mem_rvalid/mem_err outside WAIT ignored (no outstanding-beat tracking).
//  - RESP: rsp_valid=1, rsp_rdata/rsp_fault held stable until rsp_ready; then IDLE (no same-cycle re-accept).
//  - Latency (zero-wait bus): accept T, mem_valid T+1, rvalid T+2, rsp_valid T+3; misaligned rsp_valid T+1.
//  - Throughput: one request per min 4 cycles; no pipelining of outstanding requests.
//  - Reset mid-operation: immediate return to reset state; any late bus response is ignored.
// STRUCTURE
//  - mem_utils gains: mem_size_e (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10),
//    lsu_fault_e (FAULT_NONE=00, FAULT_MISALIGN=01, FAULT_BUS=10), enforce_constraints reused.
//  - FSM state enum local to this module.
//  - One combinational sub-module mem_lane_align: addr[1:0], size, wdata, rdata ->
//    wstrb, replicated wdata, shifted read word, misaligned flag.
// TESTING
//  1. LB signed 0x1003, rdata 0x80112233 -> mem_addr 0x1000, wstrb 0000, rsp_rdata 0xFFFFFF80, fault 00, rsp_valid at T+3.
//  2. LHU 0x2002, rdata 0xBEEF1234 -> rsp_rdata 0x0000BEEF; LH same -> 0xFFFFBEEF.
//  3. SB 0xA5 to 0x3001 -> mem_wdata 0xA5A5A5A5, wstrb 0010, mem_write 1; rvalid ack -> rsp_rdata 0, fault 00.
//  4. LW 0x4002 -> rsp_valid at T+1, fault 01, rdata 0, mem_valid never asserted.
//  5. TIMEOUT_CYCLES=4, bus silent -> fault 10 after 4 WAIT cycles; separate run mem_err+mem_rvalid same cycle -> fault 10.
//  6. rst_n low during WAIT -> all outputs 0, req_ready 1; late mem_rvalid ignored; rsp_ready held 0 for 3 cycles keeps rsp_* stable.

Source files
------------

// File: rtl/mem_utils_pkg.sv
// mem_utils: shared memory access types and the load result size/sign constraint helper.
`default_nettype none

package mem_utils;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_BUS      = 2'b10
  } lsu_fault_e;

  // Keeps only the bytes covered by the access size, then sign- or zero-extends them.
  function automatic logic [31:0] enforce_constraints(input logic [1:0]  size,
                                                     input logic        sign_ext,
                                                     input logic [31:0] data);
    logic [31:0] result;
    result = data;
    if (size == SIZE_BYTE)
      result = {{24{sign_ext & data[7]}}, data[7:0]};
    else if (size == SIZE_HALF)
      result = {{16{sign_ext & data[15]}}, data[15:0]};
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_lane_align.sv
// mem_lane_align: maps an access onto the 32-bit bus lanes (strobes, store replication, load shift).
`default_nettype none

module mem_lane_align
  import mem_utils::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_shifted,
  output logic        misaligned
);

  always_comb begin
    wstrb      = 4'b1111;
    wdata_lane = wdata;
    misaligned = |offset;
    if (size == SIZE_BYTE) begin
      wstrb      = 4'b0001 << offset;
      wdata_lane = {4{wdata[7:0]}};
      misaligned = 1'b0;
    end else if (size == SIZE_HALF) begin
      wstrb      = offset[1] ? 4'b1100 : 4'b0011;
      wdata_lane = {2{wdata[15:0]}};
      misaligned = offset[0];
    end
  end

  assign rdata_shifted = rdata >> {offset, 3'b000};

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store stage driving a word-aligned memory bus.
`default_nettype none

module load_store_unit
  import mem_utils::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic        req_write,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_fault,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_write,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_e;

  state_e      state;
  state_e      state_next;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic        lat_write;
  logic [CNT_W-1:0] cnt;
  logic [31:0] rdata_r;
  lsu_fault_e  fault_r;

  logic [1:0]  al_offset;
  logic [1:0]  al_size;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misaligned;
  logic        timeout;
  logic        in_issue;

  // In IDLE the aligner looks at the incoming request so misalignment is known at accept.
  assign al_offset = (state == S_IDLE) ? req_addr[1:0] : lat_addr[1:0];
  assign al_size   = (state == S_IDLE) ? req_size      : lat_size;

  mem_lane_align u_align (
    .offset        (al_offset),
    .size          (al_size),
    .wdata         (lat_wdata),
    .rdata         (mem_rdata),
    .wstrb         (al_wstrb),
    .wdata_lane    (al_wdata),
    .rdata_shifted (al_rdata),
    .misaligned    (al_misaligned)
  );

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_valid) state_next = al_misaligned ? S_RESP : S_ISSUE;
      S_ISSUE: if (mem_ready) state_next = S_WAIT;
      S_WAIT:  if (mem_err || mem_rvalid || timeout) state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      lat_write  <= 1'b0;
      cnt        <= '0;
      rdata_r    <= '0;
      fault_r    <= FAULT_NONE;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          lat_addr   <= req_addr;
          lat_wdata  <= req_wdata;
          lat_size   <= req_size;
          lat_signed <= req_signed;
          lat_write  <= req_write;
          rdata_r    <= '0;
          fault_r    <= al_misaligned ? FAULT_MISALIGN : FAULT_NONE;
        end
        S_ISSUE: if (mem_ready) cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // Error wins over a same-cycle response; a response wins over timeout.
          if (mem_err) begin
            fault_r <= FAULT_BUS;
            rdata_r <= '0;
          end else if (mem_rvalid) begin
            fault_r <= FAULT_NONE;
            rdata_r <= lat_write ? 32'd0 : enforce_constraints(lat_size, lat_signed, al_rdata);
          end else if (timeout) begin
            fault_r <= FAULT_BUS;
            rdata_r <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_issue  = (state == S_ISSUE);
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_r;
  assign rsp_fault = fault_r;
  assign mem_valid = in_issue;
  assign mem_addr  = in_issue ? {lat_addr[31:2], 2'b00} : 32'd0;
  assign mem_write = in_issue & lat_write;
  assign mem_wdata = (in_issue && lat_write) ? al_wdata : 32'd0;
  assign mem_wstrb = (in_issue && lat_write) ? al_wstrb : 4'b0000;

endmodule

`default_nettype wire
